// File: rtl/cpu_clock_controller.sv
// Clock-enable sequencer for the single-cycle CPU: turns the board clock into a
// one-cycle cpu_ce in HALT / RUN / STEP / BURST modes, with a debounced step button.
module cpu_clock_controller #(
  parameter int DIV_WIDTH       = 28,
  parameter int CNT_WIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 burst_go,
  input  logic [15:0]          burst_len,
  input  logic                 halt_req,
  output logic                 cpu_ce,
  output logic [1:0]           mode,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [15:0]          burst_remaining,
  output logic                 halted
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  mode_e                r_mode;
  logic                 r_cpu_ce;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [15:0]          r_burst_rem;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_db;
  logic                 r_db_q;
  logic [DB_W-1:0]      r_db_cnt;

  logic w_div_run;
  logic w_tick;
  logic w_step_pulse;

  assign mode            = r_mode;
  assign cpu_ce          = r_cpu_ce;
  assign cycle_count     = r_cycle_count;
  assign burst_remaining = r_burst_rem;
  assign halted          = (r_mode == MODE_HALT);

  // Divisor 0 and 1 both mean "every cycle"; a divisor lowered below the
  // current count falls into the >= compare and wraps on the next cycle.
  assign w_div_run = (r_mode == MODE_RUN) || (r_mode == MODE_BURST);
  assign w_tick    = w_div_run &&
                     ((divisor <= DIV_WIDTH'(1)) || (r_div_cnt >= divisor - DIV_WIDTH'(1)));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (!w_div_run || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_q   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_step_pulse = r_db && !r_db_q;

  // Requests are plain levels/strobes sampled on each edge with no handshake:
  // run_sw and halt_req are levels, burst_go is a one-cycle strobe that also
  // captures burst_len; requests that the current mode ignores are dropped.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_mode        <= MODE_HALT;
      r_cpu_ce      <= 1'b0;
      r_cycle_count <= '0;
      r_burst_rem   <= '0;
    end else begin
      r_cpu_ce <= 1'b0;
      case (r_mode)
        MODE_HALT: begin
          if (run_sw && !halt_req) begin
            r_mode <= MODE_RUN;
          end else if (burst_go && (burst_len != 16'd0) && !halt_req) begin
            r_mode      <= MODE_BURST;
            r_burst_rem <= burst_len;
          end else if (w_step_pulse) begin
            r_mode        <= MODE_STEP;
            r_cpu_ce      <= 1'b1;
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          end
        end
        MODE_STEP: begin
          r_mode <= MODE_HALT;
        end
        MODE_RUN: begin
          if (!run_sw || halt_req) begin
            r_mode <= MODE_HALT;
          end else if (w_tick) begin
            r_cpu_ce      <= 1'b1;
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          end
        end
        MODE_BURST: begin
          if (halt_req) begin
            r_mode <= MODE_HALT;
          end else if (w_tick) begin
            r_cpu_ce      <= 1'b1;
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            r_burst_rem   <= r_burst_rem - 16'd1;
            if (r_burst_rem == 16'd1) begin
              r_mode <= MODE_HALT;
            end
          end
        end
        default: r_mode <= MODE_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller: reset, RUN divide, debounced STEP,
// BURST (including halt_req suspension) and divisor 0/1 with counter wrap.
module tb_cpu_clock_controller;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] divisor = '0;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic          burst_go = 1'b0;
  logic [15:0]   burst_len = '0;
  logic          halt_req = 1'b0;
  logic          cpu_ce;
  logic [1:0]    mode;
  logic [CW-1:0] cycle_count;
  logic [15:0]   burst_remaining;
  logic          halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  cpu_clock_controller #(
    .DIV_WIDTH(DW),
    .CNT_WIDTH(CW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock_in(clk),
    .reset(reset),
    .divisor(divisor),
    .run_sw(run_sw),
    .step_btn(step_btn),
    .burst_go(burst_go),
    .burst_len(burst_len),
    .halt_req(halt_req),
    .cpu_ce(cpu_ce),
    .mode(mode),
    .cycle_count(cycle_count),
    .burst_remaining(burst_remaining),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock edge; inputs set and outputs sampled 1ns after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // press step_btn for 10 edges, release for 10; returns cpu_ce pulses and STEP cycles seen
  task automatic press_step(output int pulses, output int step_cycles);
    pulses = 0;
    step_cycles = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step_btn = 1'b0;
      cyc();
      if (cpu_ce) pulses++;
      if (mode == 2'b10) step_cycles++;
    end
  endtask

  initial begin
    int pulses;
    int first_idx;
    int wide;
    int step_cycles;
    logic prev_ce;
    logic [CW-1:0] exp_cnt;

    // ---------------- reset asserted mid-RUN ----------------
    divisor = 8'd4;
    cyc();
    cyc();
    reset = 1'b0;
    run_sw = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("pre_reset_mode", 32'(mode), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_rem", 32'(burst_remaining), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    run_sw = 1'b0;
    cyc();
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("post_rst_mode", 32'(mode), 32'd0);
    check("post_rst_count", 32'(cycle_count), 32'd0);
    exp_cnt = '0;

    // ---------------- RUN, divisor 4 ----------------
    run_sw = 1'b1;
    pulses = 0;
    first_idx = -1;
    wide = 0;
    prev_ce = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      cyc();
      if (cpu_ce) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
        if (prev_ce) wide++;
      end
      prev_ce = cpu_ce;
    end
    check("run_pulses", 32'(pulses), 32'd5);
    check("run_first", 32'(first_idx), 32'd5);
    check("run_width", 32'(wide), 32'd0);
    exp_cnt = exp_cnt + 4'd5;
    check("run_count", 32'(cycle_count), 32'(exp_cnt));
    check("run_mode", 32'(mode), 32'd1);
    run_sw = 1'b0;
    cyc();
    check("run_stop_mode", 32'(mode), 32'd0);
    check("run_stop_ce", 32'(cpu_ce), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (cpu_ce) pulses++;
    end
    check("halt_no_pulse", 32'(pulses), 32'd0);

    // ---------------- debounced STEP with bounce ----------------
    pulses = 0;
    step_cycles = 0;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0, 2: step_btn = 1'b1;
        1, 3: step_btn = 1'b0;
        4:    step_btn = 1'b1;
        14:   step_btn = 1'b0;
        default: ;
      endcase
      cyc();
      if (cpu_ce) begin
        pulses++;
        check("step_ce_in_step", 32'(mode), 32'd2);
      end
      if (mode == 2'b10) step_cycles++;
    end
    check("step_pulses", 32'(pulses), 32'd1);
    check("step_cycles", 32'(step_cycles), 32'd1);
    check("step_end_mode", 32'(mode), 32'd0);
    exp_cnt = exp_cnt + 4'd1;
    check("step_count", 32'(cycle_count), 32'(exp_cnt));

    // ---------------- BURST len 3, divisor 2 ----------------
    divisor = 8'd2;
    burst_len = 16'd3;
    burst_go = 1'b1;
    cyc();
    burst_go = 1'b0;
    check("burst_mode", 32'(mode), 32'd3);
    check("burst_load", 32'(burst_remaining), 32'd3);
    exp_q = {16'd2, 16'd1, 16'd0};
    pulses = 0;
    for (int i = 2; i <= 9; i++) begin
      cyc();
      if (cpu_ce) begin
        pulses++;
        check("burst_pos", 32'(i), 32'(3 + 2 * (pulses - 1)));
        if (exp_q.size() > 0) check("burst_rem", 32'(burst_remaining), 32'(exp_q.pop_front()));
        else check("burst_extra", 32'(pulses), 32'd3);
      end
    end
    check("burst_pulses", 32'(pulses), 32'd3);
    check("burst_end_mode", 32'(mode), 32'd0);
    exp_cnt = exp_cnt + 4'd3;
    check("burst_count", 32'(cycle_count), 32'(exp_cnt));

    burst_len = 16'd0;
    burst_go = 1'b1;
    cyc();
    burst_go = 1'b0;
    check("burst_zero_mode", 32'(mode), 32'd0);
    cyc();
    cyc();
    check("burst_zero_count", 32'(cycle_count), 32'(exp_cnt));

    // ---------------- BURST len 5 suspended by halt_req ----------------
    burst_len = 16'd5;
    burst_go = 1'b1;
    cyc();
    burst_go = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpu_ce) pulses++;
      if (burst_remaining == 16'd2) break;
    end
    check("susp_reach_rem", 32'(burst_remaining), 32'd2);
    check("susp_pulses", 32'(pulses), 32'd3);
    halt_req = 1'b1;
    cyc();
    check("susp_mode", 32'(mode), 32'd0);
    check("susp_ce", 32'(cpu_ce), 32'd0);
    check("susp_rem", 32'(burst_remaining), 32'd2);
    exp_cnt = exp_cnt + 4'd3;
    check("susp_count", 32'(cycle_count), 32'(exp_cnt));
    run_sw = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("halt_run_mode", 32'(mode), 32'd0);
    check("halt_run_count", 32'(cycle_count), 32'(exp_cnt));
    press_step(pulses, step_cycles);
    check("halt_step_pulses", 32'(pulses), 32'd1);
    check("halt_step_cycles", 32'(step_cycles), 32'd1);
    exp_cnt = exp_cnt + 4'd1;
    check("halt_step_count", 32'(cycle_count), 32'(exp_cnt));
    check("halt_step_rem", 32'(burst_remaining), 32'd2);
    run_sw = 1'b0;
    halt_req = 1'b0;
    burst_len = 16'd1;
    burst_go = 1'b1;
    cyc();
    burst_go = 1'b0;
    check("reload_rem", 32'(burst_remaining), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    check("reload_end_rem", 32'(burst_remaining), 32'd0);
    check("reload_end_mode", 32'(mode), 32'd0);
    exp_cnt = exp_cnt + 4'd1;
    check("reload_count", 32'(cycle_count), 32'(exp_cnt));

    // ---------------- divisor 0 then 1, counter wrap ----------------
    divisor = 8'd0;
    run_sw = 1'b1;
    cyc();
    check("div0_mode", 32'(mode), 32'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp_cnt = exp_cnt + 4'd1;
      check("div0_ce", 32'(cpu_ce), 32'd1);
      check("div0_count", 32'(cycle_count), 32'(exp_cnt));
    end
    divisor = 8'd1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp_cnt = exp_cnt + 4'd1;
      check("div1_ce", 32'(cpu_ce), 32'd1);
      check("div1_count", 32'(cycle_count), 32'(exp_cnt));
    end
    run_sw = 1'b0;
    cyc();
    check("div1_stop_mode", 32'(mode), 32'd0);
    check("div1_stop_ce", 32'(cpu_ce), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
